// File: rtl/clk_gate_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : clk_gate_ctrl_if
//  Description : Request/acknowledge bundle between the requesters of one
//                gated clock domain and the clock-gate controller.
//                  req_i   - per-requester clock request
//                  ack_o   - per-requester "gated clock running" grant
//                  en_o    - enable for the clock-gate cell
//                  state_o - controller state for debug
//                The master modport is the requester side; the slave modport
//                is the controller side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface clk_gate_ctrl_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0] ack_o;
    logic               en_o;
    logic [1:0]         state_o;

    modport master (
        output req_i,
        input  ack_o,
        input  en_o,
        input  state_o
    );

    modport slave (
        input  req_i,
        output ack_o,
        output en_o,
        output state_o
    );
endinterface
`default_nettype wire

// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clk_gate_ctrl
//  Description : Clock-gate controller for one gated clock domain shared by
//                NUM_REQ requesters. Opens the gate on any request, waits
//                WAKE_CYCLES before granting, and keeps the gate open for
//                IDLE_CYCLES quiet cycles before closing it again.
//  Ports       : clk_i  - ungated clock, all state on its rising edge
//                rst_i  - asynchronous active-high reset
//                bus    - slave side of clk_gate_ctrl_if
//                         (req_i in; ack_o, en_o, state_o out)
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_gate_ctrl #(
    parameter int NUM_REQ     = 2,   // 1..32
    parameter int WAKE_CYCLES = 2,   // 1..255
    parameter int IDLE_CYCLES = 4    // 0..255
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    clk_gate_ctrl_if.slave     bus
);

    // One counter serves both WAKE and IDLE, sized for the larger load.
    localparam int c_cnt_span = (WAKE_CYCLES > IDLE_CYCLES) ? WAKE_CYCLES : IDLE_CYCLES;
    localparam int c_cnt_max  = (c_cnt_span < 2) ? 2 : c_cnt_span;
    localparam int c_cnt_w    = $clog2(c_cnt_max);

    localparam logic [c_cnt_w-1:0] c_wake_load = c_cnt_w'(WAKE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_idle_load = c_cnt_w'((IDLE_CYCLES > 0) ? (IDLE_CYCLES - 1) : 0);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    localparam logic [1:0] c_st_off  = 2'd0;
    localparam logic [1:0] c_st_wake = 2'd1;
    localparam logic [1:0] c_st_on   = 2'd2;
    localparam logic [1:0] c_st_idle = 2'd3;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_en;

    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [1:0]         w_quiet_target;
    logic [NUM_REQ-1:0] w_req;
    logic               w_any_req;

    assign w_req     = bus.req_i;
    assign w_any_req = |w_req;

    // With no hysteresis the gate closes straight from ON.
    generate
        if (IDLE_CYCLES == 0) begin : g_no_idle
            assign w_quiet_target = c_st_off;
        end else begin : g_idle
            assign w_quiet_target = c_st_idle;
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_st_off: begin
                if (w_any_req) begin
                    w_state_nxt = c_st_wake;
                    w_cnt_nxt   = c_wake_load;
                end
            end
            c_st_wake: begin
                // Wake runs to completion even if every request has dropped.
                if (r_cnt == '0) begin
                    w_state_nxt = c_st_on;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            c_st_on: begin
                if (!w_any_req) begin
                    w_state_nxt = w_quiet_target;
                    w_cnt_nxt   = c_idle_load;
                end
            end
            c_st_idle: begin
                // Clock is still running, so a new request is granted at once.
                if (w_any_req) begin
                    w_state_nxt = c_st_on;
                end else if (r_cnt == '0) begin
                    w_state_nxt = c_st_off;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = c_st_off;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_st_off;
            r_cnt   <= '0;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_en    <= (w_state_nxt != c_st_off);
        end
    end

    // Grants follow the live requests, but only while the clock is stable.
    assign bus.ack_o   = (r_state == c_st_on) ? w_req : '0;
    assign bus.en_o    = r_en;
    assign bus.state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_gate_ctrl
//  Description : Self-checking bench for clk_gate_ctrl. Two instances:
//                dut0 (2 requesters, wake 2, idle 4) and dut1 (3 requesters,
//                wake 1, idle 0). A timeline model (gate power, cycle at which
//                the clock becomes ready, length of the current quiet run)
//                predicts en/state/ack for directed and random request
//                patterns, including asynchronous resets between edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_gate_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    clk_gate_ctrl_if #(.NUM_REQ(2)) bus0 ();
    clk_gate_ctrl_if #(.NUM_REQ(3)) bus1 ();

    clk_gate_ctrl #(
        .NUM_REQ     (2),
        .WAKE_CYCLES (2),
        .IDLE_CYCLES (4)
    ) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0.slave)
    );

    clk_gate_ctrl #(
        .NUM_REQ     (3),
        .WAKE_CYCLES (1),
        .IDLE_CYCLES (0)
    ) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1.slave)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference timeline per instance.
    int         m_wake  [2] = '{2, 1};
    int         m_idle  [2] = '{4, 0};
    bit         m_pow   [2];   // gate enabled
    int         m_ready [2];   // first cycle the clock is granted
    int         m_quiet [2];   // consecutive request-free cycles since ready
    logic [2:0] m_prev  [2];   // request vector of the previous cycle

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, obs, exp, cyc, $time);
        end
    endtask

    function automatic logic [1:0] exp_state(input int k);
        if (!m_pow[k])                              return 2'd0;
        if (cyc < m_ready[k])                       return 2'd1;
        if (cyc == m_ready[k] || m_prev[k] != '0)   return 2'd2;
        return 2'd3;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pow[k]   = 1'b0;
            m_ready[k] = 0;
            m_quiet[k] = 0;
            m_prev[k]  = '0;
        end
    endtask

    // Advance one instance across a rising edge given the requests of the cycle.
    task automatic model_edge(input int k, input logic [2:0] r);
        if (!m_pow[k]) begin
            if (r != '0) begin
                m_pow[k]   = 1'b1;
                m_ready[k] = cyc + 1 + m_wake[k];
                m_quiet[k] = 0;
            end
        end else if (cyc >= m_ready[k]) begin
            if (r == '0) begin
                m_quiet[k]++;
                if (m_quiet[k] == m_idle[k] + 1) m_pow[k] = 1'b0;
            end else begin
                m_quiet[k] = 0;
            end
        end
        m_prev[k] = r;
    endtask

    task automatic check_now(input logic [1:0] r0, input logic [2:0] r1);
        logic [1:0] s0;
        logic [1:0] s1;
        s0 = exp_state(0);
        s1 = exp_state(1);
        chk("dut0.en",    bus0.en_o,    m_pow[0]);
        chk("dut0.state", bus0.state_o, s0);
        chk("dut0.ack",   bus0.ack_o,   (s0 == 2'd2) ? r0 : 2'b00);
        chk("dut1.en",    bus1.en_o,    m_pow[1]);
        chk("dut1.state", bus1.state_o, s1);
        chk("dut1.ack",   bus1.ack_o,   (s1 == 2'd2) ? r1 : 3'b000);
    endtask

    // Called just after a falling edge: drive, check, then cross the rising edge.
    task automatic apply(input logic [1:0] r0, input logic [2:0] r1);
        bus0.req_i = r0;
        bus1.req_i = r1;
        #1;
        check_now(r0, r1);
        @(posedge clk);
        model_edge(0, {1'b0, r0});
        model_edge(1, r1);
        cyc++;
    endtask

    task automatic step(input logic [1:0] r0, input logic [2:0] r1);
        @(negedge clk);
        apply(r0, r1);
    endtask

    // Reset asserted between edges must clear outputs before the next edge.
    task automatic mid_reset(input logic [1:0] r0, input logic [2:0] r1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst.dut0.en",    bus0.en_o,    32'd0);
        chk("rst.dut0.state", bus0.state_o, 32'd0);
        chk("rst.dut0.ack",   bus0.ack_o,   32'd0);
        chk("rst.dut1.en",    bus1.en_o,    32'd0);
        chk("rst.dut1.state", bus1.state_o, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        apply(r0, r1);
    endtask

    initial begin
        logic [1:0] cur0;
        logic [2:0] cur1;

        rst        = 1'b1;
        bus0.req_i = '0;
        bus1.req_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_now(2'b00, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        apply(2'b00, 3'b000);

        // Cold wake and held grant.
        repeat (5) step(2'b01, 3'b001);
        // Hysteresis close.
        repeat (7) step(2'b00, 3'b000);
        // IDLE re-hit with a different requester.
        repeat (5) step(2'b11, 3'b010);
        repeat (2) step(2'b00, 3'b000);
        repeat (3) step(2'b10, 3'b100);
        repeat (7) step(2'b00, 3'b000);
        // Single-cycle pulse: wake completes, empty grant, then close.
        step(2'b01, 3'b001);
        repeat (10) step(2'b00, 3'b000);
        // Reset mid-IDLE, release straight into a full wake.
        repeat (5) step(2'b11, 3'b011);
        repeat (2) step(2'b00, 3'b000);
        mid_reset(2'b11, 3'b111);
        repeat (6) step(2'b11, 3'b111);
        repeat (8) step(2'b00, 3'b000);

        // Random request patterns with occasional resets.
        cur0 = '0;
        cur1 = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0)
                cur0 = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0)
                cur1 = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
            if ($urandom_range(0, 80) == 0)
                mid_reset(cur0, cur1);
            else
                step(cur0, cur1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
